// File: rtl/cpu_phase_sequencer.sv
// ---------------------------------------------------------------------------
// cpu_phase_sequencer
//
// Instruction phase sequencer for the core. Steps every instruction through
// FETCH -> DECODE -> EXECUTE -> COMMIT. It runs the memory bus handshake for
// the fetch and for an optional execute-phase data access, captures the
// instruction register and the execute-phase read data, and handles the
// interrupt acknowledge cycle and the halt/wake path.
//
// Parameters
//   DATA_WIDTH  : width of DIN, DOUT, IR, MDR, MEM_WDATA
//   ADDR_WIDTH  : width of PC_IN, MEM_ADDR, ABUS, VEC
//   WAIT_STATES : minimum extra cycles per bus access (0..15)
//   INT_VECTOR  : value driven on VEC during the interrupt acknowledge cycle
//
// Ports
//   CLK, RESETN        : clock (rising edge), asynchronous active-low reset
//   PC_IN              : fetch address from the register file
//   DIN                : memory read data
//   READYN             : memory ready, active low; high stretches a bus phase
//   MEM_REQ / MEM_WR   : execute-phase access request and direction (1=write)
//   MEM_ADDR/MEM_WDATA : execute-phase access address and write data
//   HALT_REQ           : halt instruction decoded, sampled in EXECUTE
//   INTN, IE           : interrupt request (active-low level), enable
//   ABUS, DOUT         : memory address / write data (hold outside bus phases)
//   MREQN, RD_WRN      : memory request (active low), 1=read 0=write
//   IR, MDR            : instruction register, execute-phase read data
//   FETCH..COMMIT      : one-hot phase indicators
//   INTA, VEC          : interrupt acknowledge strobe and vector
//   HALT               : core halted
// ---------------------------------------------------------------------------
module cpu_phase_sequencer #(
  parameter int                    DATA_WIDTH  = 16,
  parameter int                    ADDR_WIDTH  = 16,
  parameter int                    WAIT_STATES = 0,
  parameter logic [ADDR_WIDTH-1:0] INT_VECTOR  = ADDR_WIDTH'(16'h0002)
) (
  input  logic                  CLK,
  input  logic                  RESETN,
  input  logic [ADDR_WIDTH-1:0] PC_IN,
  input  logic [DATA_WIDTH-1:0] DIN,
  input  logic                  READYN,
  input  logic                  MEM_REQ,
  input  logic                  MEM_WR,
  input  logic [ADDR_WIDTH-1:0] MEM_ADDR,
  input  logic [DATA_WIDTH-1:0] MEM_WDATA,
  input  logic                  HALT_REQ,
  input  logic                  INTN,
  input  logic                  IE,
  output logic [ADDR_WIDTH-1:0] ABUS,
  output logic [DATA_WIDTH-1:0] DOUT,
  output logic                  MREQN,
  output logic                  RD_WRN,
  output logic [DATA_WIDTH-1:0] IR,
  output logic [DATA_WIDTH-1:0] MDR,
  output logic                  FETCH,
  output logic                  DECODE,
  output logic                  EXECUTE,
  output logic                  COMMIT,
  output logic                  INTA,
  output logic [ADDR_WIDTH-1:0] VEC,
  output logic                  HALT
);

  // One-hot state encoding; all-zero is the pre-fetch idle state after reset.
  localparam logic [5:0] ST_IDLE    = 6'b000000;
  localparam logic [5:0] ST_FETCH   = 6'b000001;
  localparam logic [5:0] ST_DECODE  = 6'b000010;
  localparam logic [5:0] ST_EXECUTE = 6'b000100;
  localparam logic [5:0] ST_COMMIT  = 6'b001000;
  localparam logic [5:0] ST_INT_ACK = 6'b010000;
  localparam logic [5:0] ST_HALTED  = 6'b100000;

  localparam logic [3:0] WS_INIT = 4'(WAIT_STATES);

  logic [5:0]            state_q;
  logic [5:0]            state_d;
  logic [3:0]            wait_cnt_q;
  logic                  exec_first_q;
  logic                  req_q;
  logic                  wr_q;
  logic                  halt_pending_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [ADDR_WIDTH-1:0] abus_q;
  logic [DATA_WIDTH-1:0] dout_q;
  logic [DATA_WIDTH-1:0] ir_q;
  logic [DATA_WIDTH-1:0] mdr_q;

  logic                  is_fetch;
  logic                  is_execute;
  logic                  is_commit;
  logic                  req_eff;
  logic                  wr_eff;
  logic [ADDR_WIDTH-1:0] addr_eff;
  logic [DATA_WIDTH-1:0] wdata_eff;
  logic                  exec_bus;
  logic                  bus_active;
  logic                  bus_done;
  logic                  exec_last;
  logic                  irq;

  assign is_fetch   = state_q[0];
  assign is_execute = state_q[2];
  assign is_commit  = state_q[3];

  // The execute-phase request is taken live on the first EXECUTE cycle and
  // from the captured copy afterwards, so decode may move on mid-phase.
  assign req_eff   = exec_first_q ? MEM_REQ   : req_q;
  assign wr_eff    = exec_first_q ? MEM_WR    : wr_q;
  assign addr_eff  = exec_first_q ? MEM_ADDR  : addr_q;
  assign wdata_eff = exec_first_q ? MEM_WDATA : wdata_q;

  assign exec_bus   = is_execute && req_eff;
  assign bus_active = is_fetch || exec_bus;

  // A bus phase ends only once the minimum wait count has expired and the
  // memory reports ready in the same cycle.
  assign bus_done  = (wait_cnt_q == 4'd0) && !READYN;
  assign exec_last = !req_eff || bus_done;
  assign irq       = !INTN && IE;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    state_d = ST_FETCH;
      ST_FETCH:   if (bus_done) state_d = ST_DECODE;
      ST_DECODE:  state_d = ST_EXECUTE;
      ST_EXECUTE: if (exec_last) state_d = ST_COMMIT;
      ST_COMMIT: begin
        if (halt_pending_q) begin
          state_d = ST_HALTED;
        end else if (irq) begin
          state_d = ST_INT_ACK;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_INT_ACK: state_d = ST_FETCH;
      ST_HALTED:  if (irq) state_d = ST_INT_ACK;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q        <= ST_IDLE;
      wait_cnt_q     <= WS_INIT;
      exec_first_q   <= 1'b0;
      req_q          <= 1'b0;
      wr_q           <= 1'b0;
      halt_pending_q <= 1'b0;
    end else begin
      state_q <= state_d;

      // Every phase change reloads the wait count, so each bus phase starts
      // with the full minimum regardless of what preceded it.
      if (state_d != state_q) begin
        wait_cnt_q <= WS_INIT;
      end else if (wait_cnt_q != 4'd0) begin
        wait_cnt_q <= wait_cnt_q - 4'd1;
      end

      exec_first_q <= (state_d == ST_EXECUTE) && (state_q != ST_EXECUTE);

      if (exec_first_q) begin
        req_q <= MEM_REQ;
        wr_q  <= MEM_WR;
      end

      if (is_execute && exec_last && HALT_REQ) begin
        halt_pending_q <= 1'b1;
      end else if (is_commit && halt_pending_q) begin
        halt_pending_q <= 1'b0;
      end
    end
  end

  // Captured access address/data are only meaningful while req_q is set.
  always_ff @(posedge CLK) begin
    if (exec_first_q) begin
      addr_q  <= MEM_ADDR;
      wdata_q <= MEM_WDATA;
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      abus_q <= '0;
      dout_q <= '0;
      ir_q   <= '0;
      mdr_q  <= '0;
    end else begin
      abus_q <= ABUS;
      dout_q <= DOUT;
      if (is_fetch && bus_done) begin
        ir_q <= DIN;
      end
      if (exec_bus && !wr_eff && bus_done) begin
        mdr_q <= DIN;
      end
    end
  end

  // Bus outputs are driven straight from the current phase so the address
  // is valid in the first bus cycle, and fall back to the held copy between
  // accesses.
  assign ABUS   = bus_active ? (is_fetch ? PC_IN : addr_eff) : abus_q;
  assign DOUT   = (exec_bus && wr_eff) ? wdata_eff : dout_q;
  assign MREQN  = !bus_active;
  assign RD_WRN = exec_bus ? !wr_eff : 1'b1;

  assign IR  = ir_q;
  assign MDR = mdr_q;

  assign FETCH   = state_q[0];
  assign DECODE  = state_q[1];
  assign EXECUTE = state_q[2];
  assign COMMIT  = state_q[3];
  assign INTA    = state_q[4];
  assign HALT    = state_q[5];
  assign VEC     = state_q[4] ? INT_VECTOR : '0;

endmodule

// File: tb/tb_cpu_phase_sequencer.sv
// ---------------------------------------------------------------------------
// tb_cpu_phase_sequencer
//
// Directed bench for cpu_phase_sequencer. Three instances share the same
// stimulus and differ only in WAIT_STATES (0, 2, 3); each section looks at
// the instance whose wait count it needs. Inputs change just after the
// falling edge and outputs are observed 1 time unit later, well away from
// the rising edge.
// ---------------------------------------------------------------------------
module tb_cpu_phase_sequencer;

  localparam logic [3:0] P_F = 4'b1000;
  localparam logic [3:0] P_D = 4'b0100;
  localparam logic [3:0] P_E = 4'b0010;
  localparam logic [3:0] P_C = 4'b0001;
  localparam logic [3:0] P_N = 4'b0000;

  logic        clk = 1'b0;
  logic        resetn;
  logic [15:0] pc_in;
  logic [15:0] din;
  logic        readyn;
  logic        mem_req;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        halt_req;
  logic        intn;
  logic        ie;

  logic [15:0] abus    [3];
  logic [15:0] dout    [3];
  logic        mreqn   [3];
  logic        rd_wrn  [3];
  logic [15:0] ir      [3];
  logic [15:0] mdr     [3];
  logic        fetch   [3];
  logic        decode  [3];
  logic        execute [3];
  logic        commit  [3];
  logic        inta    [3];
  logic [15:0] vec     [3];
  logic        halt    [3];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    cpu_phase_sequencer #(
      .DATA_WIDTH (16),
      .ADDR_WIDTH (16),
      .WAIT_STATES(g == 0 ? 0 : (g == 1 ? 2 : 3)),
      .INT_VECTOR (16'h0002)
    ) u_dut (
      .CLK      (clk),
      .RESETN   (resetn),
      .PC_IN    (pc_in),
      .DIN      (din),
      .READYN   (readyn),
      .MEM_REQ  (mem_req),
      .MEM_WR   (mem_wr),
      .MEM_ADDR (mem_addr),
      .MEM_WDATA(mem_wdata),
      .HALT_REQ (halt_req),
      .INTN     (intn),
      .IE       (ie),
      .ABUS     (abus[g]),
      .DOUT     (dout[g]),
      .MREQN    (mreqn[g]),
      .RD_WRN   (rd_wrn[g]),
      .IR       (ir[g]),
      .MDR      (mdr[g]),
      .FETCH    (fetch[g]),
      .DECODE   (decode[g]),
      .EXECUTE  (execute[g]),
      .COMMIT   (commit[g]),
      .INTA     (inta[g]),
      .VEC      (vec[g]),
      .HALT     (halt[g])
    );
  end

  function automatic logic [3:0] ph(input int i);
    return {fetch[i], decode[i], execute[i], commit[i]};
  endfunction

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_n(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_w(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reset held across one rising edge; the next rising edge enters FETCH.
  task automatic reset_pulse();
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn    = 1'b0;
    pc_in     = 16'h0100;
    din       = 16'hA5C3;
    readyn    = 1'b0;
    mem_req   = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = 16'h0000;
    mem_wdata = 16'h0000;
    halt_req  = 1'b0;
    intn      = 1'b1;
    ie        = 1'b0;

    // Reset state
    @(negedge clk); #1;
    chk_n("rst_phase",  ph(0),     P_N);
    chk_b("rst_mreqn",  mreqn[0],  1'b1);
    chk_b("rst_rd_wrn", rd_wrn[0], 1'b1);
    chk_w("rst_abus",   abus[0],   16'h0000);
    chk_w("rst_dout",   dout[0],   16'h0000);
    chk_w("rst_ir",     ir[0],     16'h0000);
    chk_w("rst_mdr",    mdr[0],    16'h0000);
    chk_b("rst_inta",   inta[0],   1'b0);
    chk_w("rst_vec",    vec[0],    16'h0000);
    chk_b("rst_halt",   halt[0],   1'b0);
    resetn = 1'b1;

    // Test 1: WAIT_STATES=0, plain instruction in 4 cycles
    @(negedge clk); #1;
    chk_n("t1_fetch",   ph(0),     P_F);
    chk_b("t1_mreqn_f", mreqn[0],  1'b0);
    chk_w("t1_abus",    abus[0],   16'h0100);
    chk_b("t1_rd_wrn",  rd_wrn[0], 1'b1);
    @(negedge clk); din = 16'h0000; #1;
    chk_n("t1_decode",  ph(0),     P_D);
    chk_w("t1_ir",      ir[0],     16'hA5C3);
    chk_b("t1_mreqn_d", mreqn[0],  1'b1);
    @(negedge clk); #1;
    chk_n("t1_execute", ph(0),     P_E);
    chk_b("t1_mreqn_e", mreqn[0],  1'b1);
    @(negedge clk); #1;
    chk_n("t1_commit",  ph(0),     P_C);
    chk_w("t1_ir_hold", ir[0],     16'hA5C3);
    @(negedge clk); #1;
    chk_n("t1_refetch", ph(0),     P_F);

    // Test 2: WAIT_STATES=2 with READYN high for two extra cycles
    readyn = 1'b1;
    reset_pulse();
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      din    = (k == 5) ? 16'h5555 : 16'h1110 + 16'(k);
      readyn = (k == 5) ? 1'b0 : 1'b1;
      #1;
      chk_n($sformatf("t2_fetch_%0d", k), ph(1),    P_F);
      chk_b($sformatf("t2_mreqn_%0d", k), mreqn[1], 1'b0);
      chk_w($sformatf("t2_ir_%0d", k),    ir[1],    16'h0000);
    end
    @(negedge clk); #1;
    chk_n("t2_decode", ph(1), P_D);
    chk_w("t2_ir",     ir[1], 16'h5555);

    // Test 3: execute-phase write then read, WAIT_STATES=2
    @(negedge clk);
    mem_req = 1'b1; mem_wr = 1'b1; mem_addr = 16'h2000; mem_wdata = 16'h1234;
    #1;
    chk_n("t3_wr_phase_1", ph(1),     P_E);
    chk_b("t3_wr_mreqn_1", mreqn[1],  1'b0);
    chk_b("t3_wr_rdwrn_1", rd_wrn[1], 1'b0);
    chk_w("t3_wr_abus_1",  abus[1],   16'h2000);
    chk_w("t3_wr_dout_1",  dout[1],   16'h1234);
    for (int k = 2; k <= 3; k++) begin
      @(negedge clk);
      mem_req = 1'b0; mem_wr = 1'b0; mem_addr = 16'hFFFF; mem_wdata = 16'hFFFF;
      #1;
      chk_n($sformatf("t3_wr_phase_%0d", k), ph(1),     P_E);
      chk_b($sformatf("t3_wr_mreqn_%0d", k), mreqn[1],  1'b0);
      chk_b($sformatf("t3_wr_rdwrn_%0d", k), rd_wrn[1], 1'b0);
      chk_w($sformatf("t3_wr_abus_%0d", k),  abus[1],   16'h2000);
      chk_w($sformatf("t3_wr_dout_%0d", k),  dout[1],   16'h1234);
    end
    @(negedge clk); #1;
    chk_n("t3_wr_commit", ph(1),     P_C);
    chk_b("t3_wr_mreqn",  mreqn[1],  1'b1);
    chk_b("t3_wr_rdwrn",  rd_wrn[1], 1'b1);
    chk_w("t3_abus_hold", abus[1],   16'h2000);
    chk_w("t3_dout_hold", dout[1],   16'h1234);
    din = 16'h0BAD;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk); #1;
      chk_n($sformatf("t3_fetch_%0d", k), ph(1), P_F);
    end
    @(negedge clk); #1;
    chk_n("t3_decode", ph(1), P_D);
    @(negedge clk);
    mem_req = 1'b1; mem_wr = 1'b0; mem_addr = 16'h3000;
    #1;
    chk_n("t3_rd_phase_1", ph(1),     P_E);
    chk_b("t3_rd_mreqn_1", mreqn[1],  1'b0);
    chk_b("t3_rd_rdwrn_1", rd_wrn[1], 1'b1);
    chk_w("t3_rd_abus_1",  abus[1],   16'h3000);
    chk_w("t3_rd_dout_1",  dout[1],   16'h1234);
    @(negedge clk);
    mem_req = 1'b0; mem_wr = 1'b1; mem_addr = 16'hFFFF;
    #1;
    chk_b("t3_rd_rdwrn_2", rd_wrn[1], 1'b1);
    chk_w("t3_rd_abus_2",  abus[1],   16'h3000);
    chk_w("t3_rd_mdr_2",   mdr[1],    16'h0000);
    @(negedge clk); din = 16'hBEEF; #1;
    chk_n("t3_rd_phase_3", ph(1),     P_E);
    chk_w("t3_rd_mdr_3",   mdr[1],    16'h0000);
    @(negedge clk); #1;
    chk_n("t3_rd_commit",  ph(1),     P_C);
    chk_w("t3_mdr",        mdr[1],    16'hBEEF);
    mem_wr = 1'b0; mem_addr = 16'h0000;

    // Test 4: interrupt acknowledge, IE=0 path and a lost interrupt
    din = 16'hA5C3;
    reset_pulse();
    @(negedge clk); #1;
    chk_n("t4_fetch", ph(0), P_F);
    @(negedge clk); intn = 1'b0; ie = 1'b1; #1;
    chk_n("t4_decode", ph(0), P_D);
    @(negedge clk); #1;
    chk_b("t4_inta_e", inta[0], 1'b0);
    @(negedge clk); #1;
    chk_n("t4_commit", ph(0),   P_C);
    chk_b("t4_inta_c", inta[0], 1'b0);
    @(negedge clk); intn = 1'b1; #1;
    chk_n("t4_ack_phase", ph(0),    P_N);
    chk_b("t4_ack_inta",  inta[0],  1'b1);
    chk_w("t4_ack_vec",   vec[0],   16'h0002);
    chk_b("t4_ack_mreqn", mreqn[0], 1'b1);
    @(negedge clk); #1;
    chk_n("t4_after_ack", ph(0),  P_F);
    chk_b("t4_inta_off",  inta[0], 1'b0);
    chk_w("t4_vec_off",   vec[0],  16'h0000);
    @(negedge clk); intn = 1'b0; ie = 1'b0;
    @(negedge clk);
    @(negedge clk); #1;
    chk_n("t4_ie0_commit", ph(0), P_C);
    @(negedge clk); #1;
    chk_n("t4_ie0_fetch", ph(0),   P_F);
    chk_b("t4_ie0_inta",  inta[0], 1'b0);
    intn = 1'b1;
    @(negedge clk); intn = 1'b0; ie = 1'b1;
    @(negedge clk); intn = 1'b1;
    @(negedge clk);
    @(negedge clk); #1;
    chk_n("t4_lost_fetch", ph(0),   P_F);
    chk_b("t4_lost_inta",  inta[0], 1'b0);
    ie = 1'b0;

    // Test 5: halt, stay halted, wake by interrupt
    reset_pulse();
    @(negedge clk);
    @(negedge clk);
    @(negedge clk); halt_req = 1'b1; #1;
    chk_n("t5_execute", ph(0), P_E);
    @(negedge clk); halt_req = 1'b0; #1;
    chk_n("t5_commit", ph(0),   P_C);
    chk_b("t5_halt_c", halt[0], 1'b0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      intn = (k >= 2) ? 1'b0 : 1'b1;
      #1;
      chk_b($sformatf("t5_halt_%0d", k),  halt[0],  1'b1);
      chk_n($sformatf("t5_phase_%0d", k), ph(0),    P_N);
      chk_b($sformatf("t5_mreqn_%0d", k), mreqn[0], 1'b1);
    end
    @(negedge clk); intn = 1'b0; ie = 1'b1; #1;
    chk_b("t5_halt_wake", halt[0], 1'b1);
    @(negedge clk); intn = 1'b1; #1;
    chk_b("t5_halt_ack", halt[0], 1'b0);
    chk_b("t5_inta",     inta[0], 1'b1);
    chk_w("t5_vec",      vec[0],  16'h0002);
    @(negedge clk); #1;
    chk_n("t5_fetch",     ph(0),   P_F);
    chk_b("t5_halt_done", halt[0], 1'b0);
    ie = 1'b0;

    // Test 6: WAIT_STATES=3, reset mid-FETCH
    din = 16'hA5C3; readyn = 1'b0;
    reset_pulse();
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk); #1;
      chk_n($sformatf("t6_fetch_%0d", k), ph(2), P_F);
    end
    @(negedge clk); #1;
    chk_n("t6_decode", ph(2), P_D);
    chk_w("t6_ir",     ir[2], 16'hA5C3);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk); #1;
    chk_n("t6_mid_fetch", ph(2),    P_F);
    chk_b("t6_mid_mreqn", mreqn[2], 1'b0);
    resetn = 1'b0;
    #1;
    chk_n("t6_rst_phase", ph(2),    P_N);
    chk_b("t6_rst_mreqn", mreqn[2], 1'b1);
    chk_w("t6_rst_ir",    ir[2],    16'h0000);
    chk_w("t6_rst_abus",  abus[2],  16'h0000);
    @(negedge clk); resetn = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk); #1;
      chk_n($sformatf("t6_refetch_%0d", k), ph(2), P_F);
    end
    @(negedge clk); #1;
    chk_n("t6_redecode", ph(2), P_D);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
